// File: rtl/registers.sv
// 32 x 32-bit integer register file: one combinational read port, one write per rising edge.
// x0 has no storage and always reads zero; writes aimed at it are dropped.
module registers #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [ADDRESS_WIDTH-1:0] read_address,
    input  logic [ADDRESS_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0]    write_value,
    output logic [DATA_WIDTH-1:0]    read_value
);

    localparam int NUM_REGS = 2 ** ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [1:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] regs_d [1:NUM_REGS-1];

    // No write enable: decode steers write_address to 0 when nothing should be written.
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (write_address == ADDRESS_WIDTH'(i)) begin
                regs_d[i] = write_value;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Address 0 matches no entry, so the mux default supplies the hard-wired zero.
    always_comb begin
        read_value = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (read_address == ADDRESS_WIDTH'(i)) begin
                read_value = regs_q[i];
            end
        end
    end

endmodule

// File: tb/tb_registers.sv
// Bench for the register file: directed writes and reads, expected values queued by the
// stimulus and compared by an independent monitor on each sample event.
`timescale 1ns/1ps
module tb_registers;

    logic        clock;
    logic        reset_n;
    logic [4:0]  read_address;
    logic [4:0]  write_address;
    logic [31:0] write_value;
    logic [31:0] read_value;

    registers #(.DATA_WIDTH(32), .ADDRESS_WIDTH(5)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .read_address  (read_address),
        .write_address (write_address),
        .write_value   (write_value),
        .read_value    (read_value)
    );

    initial clock = 1'b0;
    always #50 clock = ~clock;

    logic [31:0] exp_q [$];
    logic [4:0]  addr_q [$];
    string       tag_q [$];
    int          checks = 0;
    int          errors = 0;
    event        sample_ev;

    initial begin
        logic [31:0] e;
        logic [4:0]  a;
        string       t;
        forever begin
            @(sample_ev);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: sample with no expected value queued");
            end else begin
                e = exp_q.pop_front();
                a = addr_q.pop_front();
                t = tag_q.pop_front();
                if (read_value !== e) begin
                    errors++;
                    $display("FAIL %s: read x%0d got %h expected %h", t, a, read_value, e);
                end
            end
        end
    end

    task automatic chk(input logic [4:0] a, input logic [31:0] e, input string t);
        read_address = a;
        exp_q.push_back(e);
        addr_q.push_back(a);
        tag_q.push_back(t);
        #1;
        ->sample_ev;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        @(negedge clock);
        write_address = a;
        write_value   = v;
        @(posedge clock);
        #1;
        write_address = '0;
        write_value   = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n       = 1'b0;
        read_address  = '0;
        write_address = '0;
        write_value   = '0;
        #5;
        for (int i = 0; i < 32; i++) chk(5'(i), 32'h0, "reset_read");

        // Write attempted while reset is held must be ignored.
        @(negedge clock);
        write_address = 5'd3;
        write_value   = 32'hFFFF_FFFF;
        @(posedge clock);
        #1;
        chk(5'd3, 32'h0, "write_during_reset");
        @(negedge clock);
        write_address = '0;
        write_value   = '0;
        reset_n       = 1'b1;
        #1;
        chk(5'd3, 32'h0, "after_release");

        wr(5'd0, 32'h2);
        chk(5'd0, 32'h0, "x0_write_2");
        wr(5'd0, 32'hFFFF_FFFF);
        chk(5'd0, 32'h0, "x0_write_ones");

        // Same-address read around the write edge: old value before, new value after.
        @(negedge clock);
        write_address = 5'd2;
        write_value   = 32'h2;
        chk(5'd2, 32'h0, "no_bypass_pre_edge");
        @(posedge clock);
        #1;
        write_address = '0;
        write_value   = '0;
        chk(5'd2, 32'h2, "basic_post_edge");

        for (int i = 1; i < 32; i++) wr(5'(i), 32'hA5A5_0000 + 32'(i));
        chk(5'd0, 32'h0, "sweep_x0");
        for (int i = 1; i < 32; i++) chk(5'(i), 32'hA5A5_0000 + 32'(i), "sweep");

        wr(5'd5, 32'h1234_5678);
        chk(5'd5, 32'h1234_5678, "x5_first");
        wr(5'd5, 32'hDEAD_BEEF);
        wr(5'd6, 32'h1);
        chk(5'd5, 32'hDEAD_BEEF, "x5_overwrite");
        chk(5'd6, 32'h1, "x6_value");
        chk(5'd5, 32'hDEAD_BEEF, "x5_comb_switch");
        chk(5'd6, 32'h1, "x6_comb_switch");
        chk(5'd7, 32'hA5A5_0007, "x7_untouched");

        // Mid-simulation reset clears immediately, with no clock edge in between.
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk(5'd1, 32'h0, "midreset_x1");
        chk(5'd5, 32'h0, "midreset_x5");
        chk(5'd31, 32'h0, "midreset_x31");
        write_address = 5'd9;
        write_value   = 32'h5555_AAAA;
        @(posedge clock);
        #1;
        chk(5'd9, 32'h0, "midreset_write_blocked");
        @(negedge clock);
        write_address = '0;
        write_value   = '0;
        reset_n       = 1'b1;
        wr(5'd9, 32'h0BAD_F00D);
        chk(5'd9, 32'h0BAD_F00D, "post_reset_write");
        chk(5'd10, 32'h0, "post_reset_x10");

        for (int n = 0; n < 100 && exp_q.size() != 0; n++) #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected values left unchecked, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
